// File: rtl/life_grid_engine.sv
// Game-of-Life engine: a register-held WIDTH x HEIGHT grid advanced one generation per clock,
// with row-wise load, START/DONE run control and early stop on extinction or stability.

module life_grid_engine #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned HEIGHT       = 8,
    parameter bit          WRAP         = 1'b1,
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
    parameter int unsigned GEN_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [$clog2(HEIGHT)-1:0] load_row,
    input  logic [WIDTH-1:0]          load_data,
    output logic                      load_ready,
    input  logic                      start,
    input  logic [GEN_W-1:0]          gen_count,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   grid_out,
    output logic [GEN_W-1:0]          generation,
    output logic                      extinct,
    output logic                      stable
);

    localparam int unsigned CELLS = WIDTH * HEIGHT;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [CELLS-1:0] grid;
    logic [CELLS-1:0] next_grid;
    logic [GEN_W-1:0] remaining;
    logic [GEN_W-1:0] gen_inc;
    logic             done_pend;
    logic             next_zero;
    logic             next_same;
    logic             row_ok;
    logic             last_gen;

    // Per-cell neighbour count; the H* flags mask off neighbours that fall outside a bounded grid.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            localparam int unsigned RN = (32'(r) + HEIGHT - 32'd1) % HEIGHT;
            localparam int unsigned RS = (32'(r) + 32'd1) % HEIGHT;
            localparam int unsigned CW = (32'(c) + WIDTH - 32'd1) % WIDTH;
            localparam int unsigned CE = (32'(c) + 32'd1) % WIDTH;
            localparam int unsigned RC = 32'(r);
            localparam int unsigned CC = 32'(c);
            localparam bit HN = WRAP || (RC > 32'd0);
            localparam bit HS = WRAP || (RC + 32'd1 < HEIGHT);
            localparam bit HW = WRAP || (CC > 32'd0);
            localparam bit HE = WRAP || (CC + 32'd1 < WIDTH);

            logic [7:0] nb;
            logic [3:0] cnt;

            assign nb = {HN && HW && grid[RN*WIDTH + CW],
                         HN && grid[RN*WIDTH + CC],
                         HN && HE && grid[RN*WIDTH + CE],
                         HW && grid[RC*WIDTH + CW],
                         HE && grid[RC*WIDTH + CE],
                         HS && HW && grid[RS*WIDTH + CW],
                         HS && grid[RS*WIDTH + CC],
                         HS && HE && grid[RS*WIDTH + CE]};
            assign cnt = 4'($countones(nb));
            assign next_grid[RC*WIDTH + CC] = grid[RC*WIDTH + CC] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
        end
    end

    assign next_zero = ~|next_grid;
    assign next_same = (next_grid == grid);
    assign row_ok    = (32'(load_row) < HEIGHT);
    assign last_gen  = (remaining == GEN_W'(1));
    assign gen_inc   = (&generation) ? generation : generation + GEN_W'(1);
    assign grid_out  = grid;
    assign extinct   = ~|grid;

    // Run-control FSM; DONE is delayed one cycle behind the FINISH entry through done_pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grid       <= '0;
            remaining  <= '0;
            generation <= '0;
            stable     <= 1'b0;
            done       <= 1'b0;
            done_pend  <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (load_valid) begin
                        if (row_ok) begin
                            grid[32'(load_row)*WIDTH +: WIDTH] <= load_data;
                            generation <= '0;
                            stable     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (start) begin
                        if (gen_count == '0) begin
                            state     <= FINISH;
                            done_pend <= 1'b1;
                        end else begin
                            remaining  <= gen_count;
                            state      <= RUN;
                            busy       <= 1'b1;
                            load_ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    grid       <= next_grid;
                    remaining  <= remaining - GEN_W'(1);
                    generation <= gen_inc;
                    stable     <= next_same;
                    if (last_gen || next_zero || next_same) begin
                        state      <= FINISH;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        done_pend  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
Parametrised Game-of-Life engine holding a WIDTH x HEIGHT cell grid in registers. It advances the whole grid by one generation per clock, for a requested number of generations. Birth/survival rules and edge mode are selectable. Grid load is row-wise; run control is a START/DONE handshake with early stop on extinction or stability. Sits between the host load/readout logic and the display scan-out, and generalises the single-cell next-state rule to a full array.

Parameters:
WIDTH, 8, grid columns (>=3)
HEIGHT, 8, grid rows (>=3)
WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid read as dead
BIRTH_MASK, 9'b000001000, bit k set -> dead cell with k live neighbours is born (B3)
SURVIVE_MASK, 9'b000001100, bit k set -> live cell with k live neighbours survives (S23)
GEN_W, 16, width of generation counters

Ports:
CLK  in  1  clock; all logic rising-edge
RST  in  1  synchronous, active-high reset
LOAD_VALID  in  1  write LOAD_DATA into row LOAD_ROW
LOAD_ROW  in  $clog2(HEIGHT)  row index; row 0 = north
LOAD_DATA  in  WIDTH  row contents; bit 0 = west column
LOAD_READY  out  1  high when not in RUN
START  in  1  begin a run of GEN_COUNT generations
GEN_COUNT  in  GEN_W  generations requested; sampled with START
BUSY  out  1  high in RUN
DONE  out  1  one-cycle pulse when a run ends
GRID_OUT  out  WIDTH*HEIGHT  current grid; cell (r,c) at bit r*WIDTH+c
GENERATION  out  GEN_W  generations computed since last reset/load; saturates at all-ones
EXTINCT  out  1  combinational: grid is all zero
STABLE  out  1  last computed generation equalled its predecessor

Behaviour:
- States: IDLE, RUN, FINISH. Reset -> IDLE, grid all 0, GENERATION=0, STABLE=0, DONE=0, BUSY=0, LOAD_READY=1, EXTINCT=1.
- Next-state per cell: cnt = sum of 8 neighbours (4-bit, 0..8). next = ME ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt]. N neighbour = row-1, E = col+1.
- WRAP=1: indices wrap mod WIDTH/HEIGHT. WRAP=0: out-of-range neighbours = 0.
- Load (IDLE or FINISH only): row LOAD_ROW <= LOAD_DATA next edge; GENERATION<=0, STABLE<=0. LOAD_ROW>=HEIGHT is ignored with no state change. LOAD_VALID in RUN is ignored.
- LOAD_VALID and START in the same cycle: load wins; START is dropped.
- START in IDLE/FINISH with GEN_COUNT=0: go to FINISH, DONE pulses the next cycle, grid unchanged.
- START with GEN_COUNT>0: latch remaining = GEN_COUNT, enter RUN.
- Each RUN cycle:
  - grid <= next, remaining -= 1, GENERATION += 1 (saturating).
  - STABLE <= (next == grid).
- RUN exits to FINISH when remaining reaches 0, or when next is all-zero, or when next == grid (early stop). The exit is evaluated on the same edge as the update.
- FINISH: DONE=1 for exactly the first cycle after the RUN exit edge, then holds 0. The state stays FINISH (behaves as IDLE) until START or load.
- BUSY=1 exactly while in RUN. LOAD_READY = !BUSY. START during RUN is ignored.
- RST mid-run: on the next edge, return to the reset state; the grid is cleared.
- Latency: N generations with no early stop -> DONE is asserted N+1 cycles after the START edge.

Test Plan:
- Blinker, WRAP=0, 8x8, row3=8'b00011100, GEN_COUNT=1 -> col 3 rows 2..4 set, GENERATION=1, STABLE=0, DONE pulse; run again with 1 -> original row restored, GENERATION=2.
- 2x2 block at (3,3), GEN_COUNT=10 -> early stop after 1 cycle, GENERATION=1, STABLE=1, grid unchanged, DONE 2 cycles after START.
- Single cell, GEN_COUNT=5 -> EXTINCT=1 after 1 generation, GENERATION=1, run stops early.
- Glider at top-left, WRAP=1, GEN_COUNT=32 -> GRID_OUT equals initial pattern, GENERATION=32, BUSY high 32 cycles; with WRAP=0 the glider collapses into a block at the SE corner and stops early on stability.
- LOAD_VALID during RUN and LOAD_ROW=HEIGHT in IDLE -> grid unaffected; LOAD_READY=0 while BUSY; simultaneous LOAD_VALID+START -> row loaded, no run started.
- GEN_COUNT=0 -> DONE one cycle after START, GENERATION=0; RST asserted 3 cycles into a 10-gen run -> next cycle grid=0, BUSY=0, GENERATION=0, EXTINCT=1.
